cntr_run_ctrl: RTL and testbench
================================

Name: cntr_run_ctrl

Overview:
- Run controller for a bounded up-counter.
- Software/FSM side pulses start with a programmed range [lo..hi] and repetition count. The block then sequences the counter through that range the requested number of times, with pause and abort support.
- It reports wrap and done events.
- Default configuration lo=0, hi=10 gives the team's standard 0..10 count sequence under run control.

Parameters:
- WIDTH, 4, counter/data width.
- REP_W, 4, repetition-count width; max runs = 2^REP_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- start  input  1  request a run; sampled only in IDLE.
- pause  input  1  level; holds the count while high during a run.
- abort  input  1  terminates the run immediately.
- lo  input  WIDTH  range start; latched on accepted start.
- hi  input  WIDTH  range end (inclusive); latched on accepted start.
- reps  input  REP_W  number of full passes; latched on accepted start.
- data  output  WIDTH  current count.
- busy  output  1  high in RUN and PAUSE.
- wrap  output  1  one-cycle pulse when the count passes hi.
- rep_cnt  output  REP_W  completed passes in the current run.
- done  output  1  one-cycle pulse on normal completion.
- err  output  1  one-cycle pulse on rejected start.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a posedge) sets: state=IDLE, data=0, rep_cnt=0, busy=0, wrap=0, done=0, err=0, latched config=0. Reset overrides every other input, including mid-run.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - start=1 with lo<=hi and reps!=0: latch lo/hi/reps; next cycle data=lo, rep_cnt=0, busy=1, state=RUN.
  - start=1 with lo>hi or reps==0: err=1 for one cycle; state, data and latched config unchanged.
  - start=0: data holds its last value.
- RUN, per-edge priority abort > pause > count:
  - abort: state=IDLE, data=0, rep_cnt=0, busy=0; no done, no wrap.
  - pause: state=PAUSE; data unchanged on this edge.
  - count, data!=hi_l: data=data+1.
  - count, data==hi_l: wrap=1 and rep_cnt=rep_cnt+1.
    - If rep_cnt+1==reps_l: state=DONE, data holds hi_l.
    - Otherwise: data=lo_l and the state stays RUN.
- PAUSE:
  - abort has the same effect as in RUN.
  - pause=0: state=RUN; counting resumes on the following edge.
  - data, rep_cnt and busy are held.
- DONE: lasts one cycle; done=1, busy=0; next state=IDLE. start is ignored in DONE.
- start while busy is ignored. lo/hi/reps changes while busy are ignored (latched copies are used).
- lo==hi: every counting edge wraps; a run takes exactly reps counting edges.
- Latency: accepted start at edge k gives data=lo after edge k. A run of reps passes over range n=hi-lo+1 reaches DONE after edge k+reps*n; done is visible in the cycle after that edge.
- Arithmetic is unsigned, WIDTH bits. hi=2^WIDTH-1 is legal; the wrap compare uses equality, so no overflow occurs.

Decomposition:
- Package cntr_pkg holds the state enum (IDLE, RUN, PAUSE, DONE), the default WIDTH/REP_W constants and the default range constants LO_DEF=0, HI_DEF=10.
- One sub-module, cntr_core:
  - Ports: clk, reset, load, en, load_val, hi.
  - Outputs: data, at_hi.
  - This is a loadable bounded counter.
- cntr_run_ctrl holds the FSM, config latches, rep_cnt and event pulses.

Test Plan:
- Reset mid-run: run lo=0, hi=10, reps=3; drive reset=0 for 1 cycle at data=6 -> next cycle data=0, busy=0, state IDLE, no done.
- Default single run: lo=0, hi=10, reps=1; start at edge 0 -> data 0..10 on edges 0..10; edge 11: wrap=1, rep_cnt=1; done=1 next cycle; data stays 10; busy=0 after DONE.
- Multi-pass: lo=3, hi=5, reps=2 -> data 3,4,5,3,4,5; wrap pulses twice; done one cycle after the second wrap; rep_cnt ends at 2.
- Pause/abort:
  - pause high 4 cycles at data=7 -> data holds 7 for those cycles, resumes at 8.
  - abort while paused -> data=0, busy=0, done stays 0.
- Bad config: start with lo=9, hi=2 -> err=1 for one cycle, busy=0, data unchanged. start with reps=0 -> err=1 for one cycle.
- Ignored inputs and lo==hi: start and new lo/hi mid-run have no effect. lo=hi=4, reps=3 -> wrap high 3 consecutive cycles, then done.

Source files
------------

// File: rtl/cntr_pkg.sv
// Shared types and defaults for the run-controlled bounded up-counter.
package cntr_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int REP_W_DEF = 4;
  localparam int LO_DEF    = 0;
  localparam int HI_DEF    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cntr_core.sv
// Loadable up-counter that flags when it sits on the programmed upper bound.
import cntr_pkg::*;

module cntr_core #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] data,
  output logic             at_hi
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_val;
    end else if (en) begin
      data <= data + WIDTH'(1);
    end
  end

  // Equality against the bound means hi = all-ones never needs an overflow path.
  assign at_hi = (data == hi);

endmodule

// File: rtl/cntr_run_ctrl.sv
// Run controller: sequences cntr_core through [lo..hi] for reps passes,
// with pause/abort, and reports wrap/done/err as one-cycle registered pulses.
//
// Handshake: start is a single-cycle request honoured only in IDLE; there is
// no ready/ack, acceptance is visible as busy rising, rejection as err.
import cntr_pkg::*;

module cntr_run_ctrl #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [REP_W-1:0] reps,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             wrap,
  output logic [REP_W-1:0] rep_cnt,
  output logic             done,
  output logic             err,
  output logic [1:0]       dbg_state
);

  state_t state, state_nx;

  logic [WIDTH-1:0] lo_l, hi_l;
  logic [REP_W-1:0] reps_l;

  logic             cfg_ok;
  logic             accept, reject, kill, counting, wrap_ev, last_pass;
  logic             core_load, core_en, at_hi;
  logic [WIDTH-1:0] load_val;
  logic [REP_W-1:0] rep_nx;
  logic             busy_nx, wrap_nx, done_nx, err_nx;

  assign cfg_ok    = (lo <= hi) && (reps != '0);
  // rep_cnt < reps_l during a run, so the increment cannot overflow REP_W.
  assign last_pass = ((rep_cnt + REP_W'(1)) == reps_l);
  assign dbg_state = state;

  cntr_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .en       (core_en),
    .load_val (load_val),
    .hi       (hi_l),
    .data     (data),
    .at_hi    (at_hi)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: abort beats pause beats counting
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start && cfg_ok) state_nx = RUN;
      end
      RUN: begin
        if (abort)                    state_nx = IDLE;
        else if (pause)               state_nx = PAUSE;
        else if (at_hi && last_pass)  state_nx = DONE;
      end
      PAUSE: begin
        if (abort)       state_nx = IDLE;
        else if (!pause) state_nx = RUN;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output/datapath control, evaluated for the upcoming edge
  always_comb begin
    accept    = (state == IDLE) && start && cfg_ok;
    reject    = (state == IDLE) && start && !cfg_ok;
    kill      = ((state == RUN) || (state == PAUSE)) && abort;
    counting  = (state == RUN) && !abort && !pause;
    wrap_ev   = counting && at_hi;
    core_en   = counting && !at_hi;
    // The final wrap leaves data parked on hi, so only non-final wraps reload.
    core_load = accept || kill || (wrap_ev && !last_pass);

    if (accept)    load_val = lo;
    else if (kill) load_val = '0;
    else           load_val = lo_l;

    rep_nx = rep_cnt;
    if (accept || kill) rep_nx = '0;
    else if (wrap_ev)   rep_nx = rep_cnt + REP_W'(1);

    busy_nx = (state_nx == RUN) || (state_nx == PAUSE);
    wrap_nx = wrap_ev;
    done_nx = (state == DONE);
    err_nx  = reject;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lo_l    <= '0;
      hi_l    <= '0;
      reps_l  <= '0;
      rep_cnt <= '0;
      busy    <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (accept) begin
        lo_l   <= lo;
        hi_l   <= hi;
        reps_l <= reps;
      end
      rep_cnt <= rep_nx;
      busy    <= busy_nx;
      wrap    <= wrap_nx;
      done    <= done_nx;
      err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_cntr_run_ctrl.sv
// Bench for cntr_run_ctrl: directed scenarios plus random traffic against a
// pass/step arithmetic reference model.
import cntr_pkg::*;

module tb_cntr_run_ctrl;

  localparam int W = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [W-1:0] lo = '0, hi = '0;
  logic [R-1:0] reps = '0;
  logic [W-1:0] data;
  logic         busy, wrap, done, err;
  logic [R-1:0] rep_cnt;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;

  // Reference model: a run is a count k of counting edges out of reps*n.
  bit     m_active, m_held, m_finishing;
  int     m_lo, m_hi, m_reps, m_k;
  int     e_data, e_rep;
  bit     e_busy, e_wrap, e_done, e_err;
  state_t e_state;

  cntr_run_ctrl #(.WIDTH(W), .REP_W(R)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .lo        (lo),
    .hi        (hi),
    .reps      (reps),
    .data      (data),
    .busy      (busy),
    .wrap      (wrap),
    .rep_cnt   (rep_cnt),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    int n;
    e_wrap = 0;
    e_done = 0;
    e_err  = 0;
    if (!reset) begin
      m_active = 0; m_held = 0; m_finishing = 0;
      m_lo = 0; m_hi = 0; m_reps = 0; m_k = 0;
      e_data = 0; e_rep = 0; e_busy = 0;
    end else if (m_finishing) begin
      m_finishing = 0;
      e_done = 1;
    end else if (!m_active) begin
      if (start) begin
        if ((lo <= hi) && (reps != 0)) begin
          m_lo = lo; m_hi = hi; m_reps = reps;
          m_active = 1; m_held = 0; m_k = 0;
          e_data = m_lo; e_rep = 0; e_busy = 1;
        end else begin
          e_err = 1;
        end
      end
    end else if (abort) begin
      m_active = 0; m_held = 0;
      e_data = 0; e_rep = 0; e_busy = 0;
    end else if (m_held) begin
      if (!pause) m_held = 0;
    end else if (pause) begin
      m_held = 1;
    end else begin
      n = m_hi - m_lo + 1;
      m_k++;
      e_rep = m_k / n;
      if (m_k % n == 0) e_wrap = 1;
      if (m_k == m_reps * n) begin
        e_data = m_hi;
        m_active = 0;
        e_busy = 0;
        m_finishing = 1;
      end else begin
        e_data = m_lo + (m_k % n);
      end
    end
    if (m_finishing)              e_state = DONE;
    else if (m_active && m_held)  e_state = PAUSE;
    else if (m_active)            e_state = RUN;
    else                          e_state = IDLE;
  endtask

  task automatic compare();
    check("data",    32'(data),      32'(e_data));
    check("busy",    32'(busy),      32'(e_busy));
    check("wrap",    32'(wrap),      32'(e_wrap));
    check("rep_cnt", 32'(rep_cnt),   32'(e_rep));
    check("done",    32'(done),      32'(e_done));
    check("err",     32'(err),       32'(e_err));
    check("state",   32'(dbg_state), 32'(e_state));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input bit st, input bit pa, input bit ab, input int l,
                       input int h, input int r, input bit rs);
    start = st; pause = pa; abort = ab;
    lo = W'(l); hi = W'(h); reps = R'(r); reset = rs;
    tick();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, 0, lo, hi, reps, 1);
  endtask

  task automatic run_start(input int l, input int h, input int r);
    drive(1, 0, 0, l, h, r, 1);
  endtask

  initial begin
    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Default single run 0..10
    run_start(LO_DEF, HI_DEF, 1);
    idle(14);

    // Multi-pass 3..5 twice
    run_start(3, 5, 2);
    idle(9);

    // Pause for 4 cycles at data 7, then resume and finish
    run_start(0, 10, 1);
    idle(7);
    check("pause_at", 32'(data), 32'd7);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 10, 1, 1);
    check("pause_hold", 32'(data), 32'd7);
    idle(2);
    check("pause_resume", 32'(data), 32'd8);
    idle(6);

    // Abort while paused
    run_start(0, 10, 1);
    idle(3);
    drive(0, 1, 0, 0, 10, 1, 1);
    drive(0, 1, 1, 0, 10, 1, 1);
    idle(3);

    // Reset mid-run at data 6
    run_start(0, 10, 3);
    idle(6);
    check("rst_at", 32'(data), 32'd6);
    drive(0, 0, 0, 0, 10, 3, 0);
    idle(3);

    // Rejected configurations, one with a non-zero data to hold
    run_start(2, 4, 1);
    idle(4);
    run_start(9, 2, 1);
    idle(1);
    run_start(1, 5, 0);
    idle(1);

    // Ignored mid-run start and config changes, then lo == hi
    run_start(1, 6, 1);
    drive(1, 0, 0, 9, 12, 5, 1);
    drive(0, 0, 0, 0, 2, 3, 1);
    idle(6);
    run_start(4, 4, 3);
    idle(5);

    // Top-of-range boundary
    run_start(12, 15, 2);
    idle(10);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int l, h;
      l = $urandom_range(0, 15);
      h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(l, 15);
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 2, l, h, $urandom_range(0, 3),
            $urandom_range(0, 199) != 0);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
